// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-frame parser.
package alu_pkg;

    typedef enum logic [7:0] {
        ECHO = 8'hEC,
        ADD  = 8'hAD,
        MUL  = 8'h88,
        DIV  = 8'hD1
    } opcode_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        BAD_OP  = 2'd1,
        BAD_LEN = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        OPCODE  = 3'd0,
        RSVD    = 3'd1,
        LEN_LO  = 3'd2,
        LEN_HI  = 3'd3,
        PAYLOAD = 3'd4,
        DRAIN   = 3'd5
    } state_e;

    localparam logic [15:0] HDR_BYTES = 16'd4;

endpackage

// File: rtl/alu_word_packer.sv
// Byte-in / word-out packer: assembles bytes LSB-first into 32-bit words
// behind a single output register with same-cycle refill.
module alu_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_flush,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [23:0] asm_q;
    logic [1:0]  cnt_q;
    logic [31:0] merged;
    logic        take;

    // Handshake: a byte transfers when in_valid && in_ready at a rising edge;
    // a word transfers when out_valid && out_ready. out_valid is registered.
    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    always_comb begin
        merged = {8'h00, asm_q};
        case (cnt_q)
            2'd0:    merged[7:0]   = in_data;
            2'd1:    merged[15:8]  = in_data;
            2'd2:    merged[23:16] = in_data;
            default: merged[31:24] = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q     <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                if (cnt_q == 2'd3 || in_flush) begin
                    out_data  <= merged;
                    out_bytes <= {1'b0, cnt_q} + 3'd1;
                    out_last  <= in_flush;
                    out_valid <= 1'b1;
                    asm_q     <= '0;
                    cnt_q     <= '0;
                end else begin
                    asm_q <= merged[23:0];
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_frame_parser.sv
// Command-frame parser: decodes the 4-byte header, validates it, then either
// repacks the payload into operand words or drains a malformed frame.
module alu_frame_parser
    import alu_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_opcode_o,
    output logic [31:0] m_axis_tdata,
    output logic [2:0]  m_axis_tbytes,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  state_o
);

    state_e      state_q;
    logic [7:0]  op_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;

    logic [15:0] len_w;
    logic [15:0] plen_w;
    logic        known_op;
    logic        is_echo;
    logic        short_len;
    logic        bad_op;
    logic        bad_len;
    logic        frame_err;
    logic        accept;
    logic        pk_in_ready;
    logic        pk_in_valid;
    logic        pk_flush;

    assign state_o = state_q;

    // Header decode, evaluated while the length high byte is on the bus.
    always_comb begin
        len_w     = {s_axis_tdata, len_lo_q};
        short_len = len_w < HDR_BYTES;
        plen_w    = short_len ? 16'd0 : len_w - HDR_BYTES;
        is_echo   = op_q == ECHO;
        case (op_q)
            ECHO, ADD, MUL, DIV: known_op = 1'b1;
            default:             known_op = 1'b0;
        endcase
        bad_op    = !known_op;
        bad_len   = !bad_op &&
                    (({1'b0, len_w} > {1'b0, MAX_LEN}) || short_len ||
                     (!is_echo && (plen_w == 16'd0 || plen_w[1:0] != 2'd0)));
        frame_err = bad_op || bad_len;
    end

    // Once the final payload byte is in, stop accepting until its word leaves.
    assign s_axis_tready = !rst &&
                           ((state_q == PAYLOAD) ? (rem_q != 16'd0 && pk_in_ready) : 1'b1);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pk_in_valid   = accept && (state_q == PAYLOAD);
    assign pk_flush      = rem_q == 16'd1;

    alu_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s_axis_tdata),
        .in_valid  (pk_in_valid),
        .in_flush  (pk_flush),
        .in_ready  (pk_in_ready),
        .out_data  (m_axis_tdata),
        .out_bytes (m_axis_tbytes),
        .out_last  (m_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OPCODE;
            op_q       <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            m_opcode_o <= '0;
            err_o      <= 1'b0;
            err_code_o <= NONE;
        end else begin
            err_o <= 1'b0;
            case (state_q)
                OPCODE: if (accept) begin
                    op_q    <= s_axis_tdata;
                    state_q <= RSVD;
                end
                RSVD: if (accept) begin
                    state_q <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len_lo_q <= s_axis_tdata;
                    state_q  <= LEN_HI;
                end
                LEN_HI: if (accept) begin
                    rem_q <= plen_w;
                    if (frame_err) begin
                        err_o      <= 1'b1;
                        err_code_o <= bad_op ? BAD_OP : BAD_LEN;
                        state_q    <= (plen_w != 16'd0) ? DRAIN : OPCODE;
                    end else if (plen_w == 16'd0) begin
                        state_q <= OPCODE;
                    end else begin
                        m_opcode_o <= op_q;
                        state_q    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        rem_q <= rem_q - 16'd1;
                    end
                    if (rem_q == 16'd0 && m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        state_q <= OPCODE;
                    end
                end
                DRAIN: if (accept) begin
                    rem_q <= rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_q <= OPCODE;
                    end
                end
                default: state_q <= OPCODE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_parser.sv
// Directed bench for alu_frame_parser: header decode, packing, errors,
// backpressure and mid-frame reset.
module tb_alu_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_opcode_o;
    logic [31:0] m_axis_tdata;
    logic [2:0]  m_axis_tbytes;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [2:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Word record: {opcode, last, bytes, data}
    logic [43:0] exp_q[$];
    logic [43:0] got_q[$];
    logic [1:0]  err_q[$];
    logic [7:0]  frame_q[$];
    logic        stall_q = 1'b0;
    logic [43:0] held_q  = '0;
    logic [43:0] cur;

    always #5 clk = ~clk;

    alu_frame_parser dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_opcode_o    (m_opcode_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tbytes (m_axis_tbytes),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .state_o       (state_o)
    );

    function automatic logic [43:0] w(input logic [7:0] op, input logic last,
                                      input logic [2:0] nb, input logic [31:0] d);
        return {op, last, nb, d};
    endfunction

    // Output monitor: records handshaken words and error pulses, checks hold.
    always @(negedge clk) begin
        cur = {m_opcode_o, m_axis_tlast, m_axis_tbytes, m_axis_tdata};
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_cmp++;
                if (!m_axis_tvalid || cur !== held_q) begin
                    n_bad++;
                    $display("FAIL hold: got valid=%b word=%h required valid=1 word=%h",
                             m_axis_tvalid, cur, held_q);
                end
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
            if (err_o) err_q.push_back(err_code_o);
            stall_q = m_axis_tvalid && !m_axis_tready;
            held_q  = cur;
        end
    end

    // Drivers: entered and left at posedge+#1.
    task automatic send_byte(input logic [7:0] b);
        int   budget;
        logic acc;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        budget = 0;
        acc    = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance",
                         b, budget);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 ||
            m_axis_tbytes !== 3'd0 || m_axis_tlast !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tready=%b tvalid=%b tdata=%h tbytes=%0d tlast=%b required all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tbytes, m_axis_tlast);
        end
        n_cmp++;
        if (m_opcode_o !== 8'h00 || err_o !== 1'b0 || err_code_o !== 2'd0 || state_o !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_status: got op=%h err=%b code=%0d state=%0d required 0 0 0 0",
                     m_opcode_o, err_o, err_code_o, state_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_after: got %b required 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        got_q.delete(); err_q.delete();
        exp_q = '{w(8'hAD, 1'b0, 3'd4, 32'h00000001), w(8'hAD, 1'b1, 3'd4, 32'h00000002)};
        frame_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                    8'h02, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_out();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL add_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL add_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_bad++;
            $display("FAIL add_err: got %0d error pulses required 0", err_q.size());
        end
    endtask

    task automatic test_echo();
        got_q.delete(); err_q.delete();
        exp_q = '{w(8'hEC, 1'b1, 3'd3, 32'h00434241),
                  w(8'hEC, 1'b0, 3'd4, 32'h64636261),
                  w(8'hEC, 1'b1, 3'd2, 32'h00006665)};
        frame_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43,
                    8'hEC, 8'h5A, 8'h04, 8'h00,
                    8'hEC, 8'h00, 8'h0A, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        send_frame();
        wait_out();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL echo_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL echo_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_bad++;
            $display("FAIL echo_err: got %0d error pulses required 0", err_q.size());
        end
    endtask

    task automatic test_bad_op();
        got_q.delete(); err_q.delete();
        exp_q = '{w(8'hAD, 1'b0, 3'd4, 32'h00000001), w(8'hAD, 1'b1, 3'd4, 32'h00000002)};
        frame_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
                    8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                    8'h02, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_out();
        n_cmp++;
        if (err_q.size() != 1 || err_q[0] !== 2'd1) begin
            n_bad++;
            $display("FAIL bad_op_err: got %0d pulses first code=%0d required 1 pulse code=1",
                     err_q.size(), (err_q.size() > 0) ? err_q[0] : 2'd0);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL bad_op_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bad_op_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bad_len();
        got_q.delete(); err_q.delete();
        exp_q = '{w(8'hAD, 1'b1, 3'd4, 32'h08070605)};
        frame_q = '{8'h88, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22,
                    8'hAD, 8'h00, 8'h02, 8'h00,
                    8'hAD, 8'h00, 8'h08, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame();
        wait_out();
        n_cmp++;
        if (err_q.size() != 2 || err_q[0] !== 2'd2 || err_q[1] !== 2'd2) begin
            n_bad++;
            $display("FAIL bad_len_err: got %0d pulses required 2 pulses code=2", err_q.size());
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_bad++;
            $display("FAIL bad_len_word: got %0d words first=%h required 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 44'h0, exp_q[0]);
        end
        n_cmp++;
        if (err_code_o !== 2'd2) begin
            n_bad++;
            $display("FAIL bad_len_code_held: got %0d required 2", err_code_o);
        end
    endtask

    task automatic test_backpressure();
        got_q.delete(); err_q.delete();
        exp_q = '{w(8'hAD, 1'b0, 3'd4, 32'h04030201), w(8'hAD, 1'b0, 3'd4, 32'h08070605),
                  w(8'hAD, 1'b1, 3'd4, 32'h0C0B0A09)};
        frame_q = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        m_axis_tready = 1'b0;
        fork
            send_frame();
            begin
                repeat (20) @(negedge clk);
                n_cmp++;
                if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h04030201) begin
                    n_bad++;
                    $display("FAIL bp_stall: got s_tready=%b m_tvalid=%b tdata=%h required 0 1 04030201",
                             s_axis_tready, m_axis_tvalid, m_axis_tdata);
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_out();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL bp_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        // Reset with a partial word in the packer.
        got_q.delete(); err_q.delete();
        frame_q = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || state_o !== 3'd0 || s_axis_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_partial: got tvalid=%b state=%0d s_tready=%b required 0 0 0",
                     m_axis_tvalid, state_o, s_axis_tready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== w(8'hAD, 1'b0, 3'd4, 32'h04030201)) begin
            n_bad++;
            $display("FAIL rst_mid_first: got %0d words required 1 word 04030201", got_q.size());
        end
        // Reset with an output word stalled downstream.
        m_axis_tready = 1'b0;
        frame_q = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14};
        send_frame();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_pending: got tvalid=%b required 0", m_axis_tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        got_q.delete();
        exp_q = '{w(8'hAD, 1'b1, 3'd4, 32'hF4F3F2F1)};
        frame_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        send_frame();
        wait_out();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_bad++;
            $display("FAIL rst_mid_fresh: got %0d words first=%h required 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 44'h0, exp_q[0]);
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_mid_err: got %0d error pulses required 0", err_q.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_add();
        test_echo();
        test_bad_op();
        test_bad_len();
        test_backpressure();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
